// File: rtl/dsc_q_table_arbiter_pkg.sv
// Shared types and constants for the descriptor-queue state table arbiter.
package dsc_q_table_arbiter_pkg;

  localparam int STARVE_W = 8;
  localparam int EVENTS_W = 16;
  localparam int Q_AW     = 13;
  localparam int Q_DW     = 32;

  typedef enum logic {
    OWNER_DP  = 1'b0,
    OWNER_CFG = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    QS_TAIL,
    QS_HEAD,
    QS_ADDR_LO,
    QS_ADDR_HI
  } queue_state_t;

  // Request bundle at the default table geometry (8192 queues, 32-bit words).
  typedef struct packed {
    logic            wr;
    logic [Q_AW-1:0] addr;
    logic [Q_DW-1:0] wdata;
  } bram_req_t;

  function automatic logic [EVENTS_W-1:0] satIncEvents(input logic [EVENTS_W-1:0] v);
    return (&v) ? v : v + EVENTS_W'(1);
  endfunction

endpackage

// File: rtl/bram_interface_io.sv
// Single BRAM port: address, write data and enable out, read data back.
interface bram_interface_io #(
  parameter int AW = 13,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [DW-1:0] rd_data;

  modport owner  (output addr, output wr_data, output wr_en, input rd_data);
  modport memory (input addr, input wr_data, input wr_en, output rd_data);
endinterface

// File: rtl/dsc_q_table_arbiter_tag_pipe.sv
// Fixed-depth valid/payload shift register used to route read responses to their issuer.
module fixed_latency_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_payload_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_payload_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] payload_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) payload_q[i] <= '0;
    end else begin
      valid_q[0]   <= in_valid_i;
      payload_q[0] <= in_payload_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i]   <= valid_q[i-1];
        payload_q[i] <= payload_q[i-1];
      end
    end
  end

  assign out_valid_o   = valid_q[DEPTH-1];
  assign out_payload_o = payload_q[DEPTH-1];

endmodule

// File: rtl/dsc_q_table_arbiter.sv
// Shares one q_table BRAM port between the queue-manager datapath and the MMIO config path,
// with a starvation counter that periodically forces a config grant.
module dsc_q_table_arbiter
  import dsc_q_table_arbiter_pkg::*;
#(
  parameter int NB_QUEUES    = 8192,
  parameter int DW           = 32,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 16,
  localparam int AW          = $clog2(NB_QUEUES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dp_req_valid,
  output logic                  dp_req_ready,
  input  logic                  dp_req_wr,
  input  logic [AW-1:0]         dp_req_addr,
  input  logic [DW-1:0]         dp_req_wdata,
  output logic                  dp_rd_valid,
  output logic [DW-1:0]         dp_rd_data,
  input  logic                  cfg_req_valid,
  output logic                  cfg_req_ready,
  input  logic                  cfg_req_wr,
  input  logic [AW-1:0]         cfg_req_addr,
  input  logic [DW-1:0]         cfg_req_wdata,
  output logic                  cfg_rd_valid,
  output logic [DW-1:0]         cfg_rd_data,
  bram_interface_io.owner       q_table,
  output logic [EVENTS_W-1:0]   starve_events
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;
  logic [EVENTS_W-1:0] starveEvents_q, starveEvents_d;
  logic [AW-1:0]       addr_q, addr_d;

  logic          forceCfg, grantDp, grantCfg, granted, grantWr;
  logic [AW-1:0] grantAddr;
  logic [DW-1:0] grantWdata;

  logic       tagInValid, tagOutValid;
  logic [0:0] tagInOwner, tagOutOwner;

  // Grant depends only on valids and registered starve state, never on ready.
  always_comb begin
    forceCfg   = dp_req_valid && cfg_req_valid && (starveCnt_q == LIMIT);
    grantCfg   = !rst && cfg_req_valid && (!dp_req_valid || forceCfg);
    grantDp    = !rst && dp_req_valid && !forceCfg;
    granted    = grantDp || grantCfg;
    grantWr    = grantCfg ? cfg_req_wr    : dp_req_wr;
    grantAddr  = grantCfg ? cfg_req_addr  : dp_req_addr;
    grantWdata = grantCfg ? cfg_req_wdata : dp_req_wdata;
  end

  always_comb begin
    starveCnt_d    = starveCnt_q;
    starveEvents_d = starveEvents_q;
    if (!cfg_req_valid || grantCfg) begin
      starveCnt_d = '0;
    end else if (starveCnt_q < LIMIT) begin
      starveCnt_d = starveCnt_q + STARVE_W'(1);
    end
    if (forceCfg) begin
      starveEvents_d = satIncEvents(starveEvents_q);
    end
  end

  assign addr_d = granted ? grantAddr : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt_q    <= '0;
      starveEvents_q <= '0;
      addr_q         <= '0;
    end else begin
      starveCnt_q    <= starveCnt_d;
      starveEvents_q <= starveEvents_d;
      addr_q         <= addr_d;
    end
  end

  assign q_table.addr    = addr_d;
  assign q_table.wr_data = grantWdata;
  assign q_table.wr_en   = granted && grantWr;

  assign tagInValid = granted && !grantWr;
  assign tagInOwner = grantCfg ? OWNER_CFG : OWNER_DP;

  fixed_latency_tag_pipe #(
    .DEPTH (RD_LATENCY),
    .WIDTH (1)
  ) u_tag_pipe (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (tagInValid),
    .in_payload_i  (tagInOwner),
    .out_valid_o   (tagOutValid),
    .out_payload_o (tagOutOwner)
  );

  assign dp_req_ready  = grantDp;
  assign cfg_req_ready = grantCfg;
  assign dp_rd_valid   = tagOutValid && (tagOutOwner == OWNER_DP);
  assign cfg_rd_valid  = tagOutValid && (tagOutOwner == OWNER_CFG);
  assign dp_rd_data    = q_table.rd_data;
  assign cfg_rd_data   = q_table.rd_data;
  assign starve_events = starveEvents_q;

endmodule

// File: tb/tb_dsc_q_table_arbiter.sv
// Table-driven bench for dsc_q_table_arbiter with a behavioural BRAM and a read-response scoreboard.
module tb_dsc_q_table_arbiter;

  localparam int NBQ    = 64;
  localparam int AW     = $clog2(NBQ);
  localparam int DW     = 32;
  localparam int RDL    = 2;
  localparam int SLIMIT = 4;

  typedef struct {
    logic          dpV;
    logic          dpWr;
    logic [AW-1:0] dpAddr;
    logic [DW-1:0] dpData;
    logic          cfgV;
    logic          cfgWr;
    logic [AW-1:0] cfgAddr;
    logic [DW-1:0] cfgData;
    logic          expDp;
    logic          expCfg;
  } vec_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          dp_req_valid, dp_req_ready, dp_req_wr;
  logic [AW-1:0] dp_req_addr;
  logic [DW-1:0] dp_req_wdata;
  logic          dp_rd_valid;
  logic [DW-1:0] dp_rd_data;
  logic          cfg_req_valid, cfg_req_ready, cfg_req_wr;
  logic [AW-1:0] cfg_req_addr;
  logic [DW-1:0] cfg_req_wdata;
  logic          cfg_rd_valid;
  logic [DW-1:0] cfg_rd_data;
  logic [15:0]   starve_events;

  bram_interface_io #(.AW(AW), .DW(DW)) qTable ();

  logic [DW-1:0] mem    [NBQ];
  logic [DW-1:0] refMem [NBQ];
  logic [DW-1:0] rdPipe [RDL];

  resp_t dpQ[$];
  resp_t cfgQ[$];
  vec_t  vecs[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  dsc_q_table_arbiter #(
    .NB_QUEUES    (NBQ),
    .DW           (DW),
    .RD_LATENCY   (RDL),
    .STARVE_LIMIT (SLIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dp_req_valid  (dp_req_valid),
    .dp_req_ready  (dp_req_ready),
    .dp_req_wr     (dp_req_wr),
    .dp_req_addr   (dp_req_addr),
    .dp_req_wdata  (dp_req_wdata),
    .dp_rd_valid   (dp_rd_valid),
    .dp_rd_data    (dp_rd_data),
    .cfg_req_valid (cfg_req_valid),
    .cfg_req_ready (cfg_req_ready),
    .cfg_req_wr    (cfg_req_wr),
    .cfg_req_addr  (cfg_req_addr),
    .cfg_req_wdata (cfg_req_wdata),
    .cfg_rd_valid  (cfg_rd_valid),
    .cfg_rd_data   (cfg_rd_data),
    .q_table       (qTable),
    .starve_events (starve_events)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: write on the edge, read data emerges RDL cycles after the address.
  always @(posedge clk) begin
    if (qTable.wr_en) mem[qTable.addr] <= qTable.wr_data;
    rdPipe[0] <= mem[qTable.addr];
    for (int i = 1; i < RDL; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign qTable.rd_data = rdPipe[RDL-1];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input int dpV, input int dpWr, input int dpA, input logic [DW-1:0] dpD,
                                 input int cfgV, input int cfgWr, input int cfgA, input logic [DW-1:0] cfgD,
                                 input int expDp, input int expCfg);
    vec_t v;
    v.dpV     = (dpV != 0);
    v.dpWr    = (dpWr != 0);
    v.dpAddr  = AW'(dpA);
    v.dpData  = dpD;
    v.cfgV    = (cfgV != 0);
    v.cfgWr   = (cfgWr != 0);
    v.cfgAddr = AW'(cfgA);
    v.cfgData = cfgD;
    v.expDp   = (expDp != 0);
    v.expCfg  = (expCfg != 0);
    return v;
  endfunction

  function automatic vec_t idleVec();
    return mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic checkValue(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drive the request lines and record what the accepted access should later produce.
  task automatic applyStimulus(input vec_t v);
    dp_req_valid  = v.dpV;
    dp_req_wr     = v.dpWr;
    dp_req_addr   = v.dpAddr;
    dp_req_wdata  = v.dpData;
    cfg_req_valid = v.cfgV;
    cfg_req_wr    = v.cfgWr;
    cfg_req_addr  = v.cfgAddr;
    cfg_req_wdata = v.cfgData;
    if (v.expDp && !v.dpWr) dpQ.push_back('{due: cyc + RDL, data: refMem[v.dpAddr]});
    if (v.expDp && v.dpWr) refMem[v.dpAddr] = v.dpData;
    if (v.expCfg && !v.cfgWr) cfgQ.push_back('{due: cyc + RDL, data: refMem[v.cfgAddr]});
    if (v.expCfg && v.cfgWr) refMem[v.cfgAddr] = v.cfgData;
  endtask

  task automatic checkOutput(input vec_t v);
    logic expDpV, expCfgV;
    checkValue("dp_req_ready", DW'(dp_req_ready), DW'(v.expDp));
    checkValue("cfg_req_ready", DW'(cfg_req_ready), DW'(v.expCfg));
    checkValue("wr_en", DW'(qTable.wr_en), DW'((v.expDp && v.dpWr) || (v.expCfg && v.cfgWr)));
    if (v.expDp) checkValue("bram_addr", DW'(qTable.addr), DW'(v.dpAddr));
    else if (v.expCfg) checkValue("bram_addr", DW'(qTable.addr), DW'(v.cfgAddr));
    expDpV  = (dpQ.size() > 0) && (dpQ[0].due == cyc);
    expCfgV = (cfgQ.size() > 0) && (cfgQ[0].due == cyc);
    checkValue("dp_rd_valid", DW'(dp_rd_valid), DW'(expDpV));
    checkValue("cfg_rd_valid", DW'(cfg_rd_valid), DW'(expCfgV));
    if (expDpV) begin
      checkValue("dp_rd_data", dp_rd_data, dpQ[0].data);
      void'(dpQ.pop_front());
    end
    if (expCfgV) begin
      checkValue("cfg_rd_data", cfg_rd_data, cfgQ[0].data);
      void'(cfgQ.pop_front());
    end
  endtask

  task automatic stepCycle(input vec_t v);
    #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < NBQ; i++) begin
      mem[i]    = 32'hA000_0000 + DW'(i);
      refMem[i] = 32'hA000_0000 + DW'(i);
    end
    mem[5]    = 32'hDEAD_BEEF;
    refMem[5] = 32'hDEAD_BEEF;

    // Columns: dpV dpWr dpAddr dpData | cfgV cfgWr cfgAddr cfgData | expDpReady expCfgReady
    vecs.push_back(mkVec(1, 0,  1, 0,       1, 0,  2, 0,       1, 0));
    vecs.push_back(idleVec());
    vecs.push_back(mkVec(0, 0,  0, 0,       1, 0,  5, 0,       0, 1));
    vecs.push_back(idleVec());
    vecs.push_back(idleVec());
    vecs.push_back(mkVec(1, 0,  3, 0,       0, 0,  0, 0,       1, 0));
    vecs.push_back(mkVec(0, 0,  0, 0,       1, 0,  7, 0,       0, 1));
    vecs.push_back(mkVec(1, 1, 10, 32'h55,  0, 0,  0, 0,       1, 0));
    vecs.push_back(mkVec(1, 0, 10, 0,       0, 0,  0, 0,       1, 0));
    vecs.push_back(mkVec(0, 0,  0, 0,       1, 1,  9, 32'h10,  0, 1));
    vecs.push_back(mkVec(1, 0,  9, 0,       0, 0,  0, 0,       1, 0));
    vecs.push_back(mkVec(1, 0, 12, 0,       1, 1, 12, 32'h77,  1, 0));
    vecs.push_back(mkVec(0, 0,  0, 0,       1, 1, 12, 32'h77,  0, 1));
    vecs.push_back(mkVec(1, 0, 12, 0,       0, 0,  0, 0,       1, 0));
    vecs.push_back(idleVec());
    for (int k = 0; k < SLIMIT; k++)
      vecs.push_back(mkVec(1, 0, 20 + k, 0, 1, 1, 30, 32'hCAFE, 1, 0));
    vecs.push_back(mkVec(1, 0, 24, 0,       1, 1, 30, 32'hCAFE, 0, 1));
    vecs.push_back(mkVec(1, 0, 24, 0,       0, 0,  0, 0,       1, 0));
    vecs.push_back(mkVec(1, 0, 30, 0,       0, 0,  0, 0,       1, 0));
    vecs.push_back(idleVec());
    vecs.push_back(idleVec());

    // Reset with every requester asserting valid: nothing may be granted.
    rst = 1'b1;
    applyStimulus(mkVec(1, 1, 3, 32'h11, 1, 1, 4, 32'h22, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput(mkVec(1, 1, 3, 32'h11, 1, 1, 4, 32'h22, 0, 0));
    checkValue("reset_addr", DW'(qTable.addr), 0);
    checkValue("reset_starve_events", DW'(starve_events), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;

    foreach (vecs[i]) stepCycle(vecs[i]);

    @(negedge clk);
    checkValue("starve_events_after_force", DW'(starve_events), 1);
    @(posedge clk);
    cyc++;

    // Reset with two reads in flight: their responses must never appear.
    stepCycle(mkVec(1, 0, 3, 0, 0, 0, 0, 0, 1, 0));
    stepCycle(mkVec(0, 0, 0, 0, 1, 0, 7, 0, 0, 1));
    #1 rst = 1'b1;
    dpQ.delete();
    cfgQ.delete();
    stepCycle(idleVec());
    stepCycle(idleVec());
    #1 rst = 1'b0;
    repeat (4) stepCycle(idleVec());
    @(negedge clk);
    checkValue("starve_events_after_reset", DW'(starve_events), 0);
    @(posedge clk);
    cyc++;

    stepCycle(mkVec(1, 0, 5, 0, 0, 0, 0, 0, 1, 0));
    stepCycle(idleVec());
    stepCycle(idleVec());
    checkValue("scoreboard_drained", DW'(dpQ.size() + cfgQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsc_q_table_arbiter.md
# dsc_q_table_arbiter

Shares one port of a descriptor-queue state BRAM (tails, heads, low or high addresses) between two requesters. The requesters are the descriptor queue-manager datapath and the PCIe BAR/MMIO configuration path, which handles software head updates, buffer-address programming and readback. The datapath normally wins; a starvation counter guarantees the config path forward progress. Read responses are routed back to the issuer through a fixed-latency tag pipeline. One instance sits in front of each q_table BRAM feeding the descriptor queue manager.

## Interface
Parameters:
- NB_QUEUES, 8192: number of descriptor queues; address width AW = $clog2(NB_QUEUES).
- DW, 32: BRAM data width.
- RD_LATENCY, 2: BRAM read latency in cycles; must be ≥1.
- STARVE_LIMIT, 16: cycles config may wait before a forced grant; range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- dp_req_valid  in  1  datapath request.
- dp_req_ready  out  1  datapath request accepted this cycle.
- dp_req_wr  in  1  1 = write, 0 = read.
- dp_req_addr  in  AW  queue id.
- dp_req_wdata  in  DW  write data.
- dp_rd_valid  out  1  datapath read data valid.
- dp_rd_data  out  DW  datapath read data.
- cfg_req_valid, cfg_req_ready, cfg_req_wr, cfg_req_addr, cfg_req_wdata: same roles for the config path.
- cfg_rd_valid  out  1  config read data valid.
- cfg_rd_data  out  DW  config read data.
- q_table  bram_interface_io.owner  —  shared BRAM port (addr, wr_data, wr_en, rd_data).
- starve_events  out  16  saturating count of forced config grants.

## Operation
- The BRAM port performs at most one access per cycle. An access is accepted when valid && ready.
- Arbitration is purely combinational on the current valids and the registered starve state:
  - Only one requester valid: that requester is granted.
  - Both valid and starve_cnt < STARVE_LIMIT: grant dp.
  - Both valid and starve_cnt == STARVE_LIMIT: grant cfg, and increment starve_events, saturating at 0xFFFF.
- ready is asserted only toward the granted requester. Grant never depends on ready, so there are no combinational loops.
- starve_cnt is 8 bits:
  - cleared on any cfg grant, or whenever cfg_req_valid is low;
  - incremented each cycle cfg_req_valid is high and not granted;
  - never exceeds STARVE_LIMIT.
- Granted access drives q_table.addr and q_table.wr_data, and drives q_table.wr_en = granted && wr. With no grant, wr_en = 0 and addr holds its last value.
- Tag pipeline, RD_LATENCY stages deep:
  - Entry pushed each cycle = {valid = granted read, owner = dp or cfg}.
  - At the pipeline output, x_rd_valid pulses for one cycle for the recorded owner.
  - x_rd_data = q_table.rd_data for both owners; it is qualified only by that owner's rd_valid.
- A write and a later read to the same address issued in consecutive cycles return the new data; the BRAM is read-after-write coherent. The arbiter adds no hazard logic.
- The arbiter does not reorder requests. Responses to each owner return in acceptance order, with a fixed RD_LATENCY.

## Timing
- Reset values: dp_req_ready = cfg_req_ready = 0 while rst is high; all rd_valid = 0; tag pipeline cleared; starve_cnt = 0; starve_events = 0; q_table.wr_en = 0; q_table.addr = 0.
- Request-to-BRAM latency is 0 cycles (combinational grant). Read response arrives exactly RD_LATENCY cycles after acceptance.
- Sustained throughput is 1 access per cycle. Under continuous dp traffic, cfg gets exactly 1 slot in every STARVE_LIMIT+1 cycles.
- Reset asserted mid-operation: in-flight reads are dropped, and no rd_valid is produced after reset deassertion for pre-reset requests.
- Simultaneous cfg write and dp read to the same address in the same cycle: only one is granted. The loser retries next cycle and observes the winner's effect.

## Structure
- The starve counter width and bram_req_t (wr, addr, wdata) belong in pcie_consts.sv alongside queue_state_t.
- One sub-module, fixed_latency_tag_pipe (parameters DEPTH and WIDTH; valid and payload shift register with async reset), is reused for response routing.

## Test plan
- Reset: drive all valids high during rst -> both readies 0, wr_en 0; after release, dp is granted first.
- Lone cfg read of addr 5 (preloaded 0xDEADBEEF) -> cfg_rd_valid is high exactly 2 cycles later with 0xDEADBEEF; dp_rd_valid stays 0.
- Continuous dp reads plus a cfg write pending, STARVE_LIMIT = 4 -> cfg is granted on the 5th cycle of waiting; starve_events = 1; dp stalls for exactly 1 cycle.
- Interleaved dp read (addr 3) and cfg read (addr 7) in back-to-back cycles -> responses arrive at their owners in order, 2 cycles apart from issue, with no cross-routing.
- cfg write 0x10 to addr 9, then dp read of addr 9 on the next cycle -> dp_rd_data = 0x10.
- Assert rst while 2 reads are in flight -> no rd_valid pulses after release; starve_events returns to 0.
